// File: rtl/imem_boot_ctrl.sv
// Boot loader for i_mem: decodes LOAD/RUN commands from a UART byte stream, writes payload into i_mem
// and holds the CPU while loading. Optional payload checksum stage enabled by IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter logic [7:0]  CMD_LOAD   = 8'hA5,
   parameter logic [7:0]  CMD_RUN    = 8'h5A
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic [ADDR_WIDTH-1:0] cpu_r_addr,
   input  logic                  cpu_r_en,
   output logic                  cpu_hold,
   output logic [ADDR_WIDTH-1:0] mem_w_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_w_en,
   output logic [ADDR_WIDTH-1:0] mem_r_addr,
   output logic                  mem_r_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned FIELD_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_LEN_H,
      S_LEN_L,
      S_DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CSUM,
`endif
      S_RUN
   } state_t;

   state_t                r_state;
   logic                  r_rx_ready;
   logic                  r_cpu_hold;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_w_en;
   logic [ADDR_WIDTH-1:0] r_w_addr;
   logic [DATA_WIDTH-1:0] r_din;
   logic [FIELD_W-1:0]    r_addr;
   logic [FIELD_W-1:0]    r_len;
   logic                  w_acc;
   logic                  w_run_ok;
   logic [FIELD_W-1:0]    w_len_full;

   assign w_acc      = rx_valid & r_rx_ready;
   assign w_len_full = {r_len[15:8], rx_data};

`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0] r_sum;
   logic       r_err;
   assign err      = r_err;
   // A failed checksum keeps the CPU parked until a fresh load succeeds
   assign w_run_ok = ~r_err;
`else
   assign err      = 1'b0;
   assign w_run_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rx_ready <= 1'b0;
         r_cpu_hold <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_w_en     <= 1'b0;
         r_w_addr   <= '0;
         r_din      <= '0;
         r_addr     <= '0;
         r_len      <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         r_sum      <= '0;
         r_err      <= 1'b0;
`endif
      end else begin
         r_rx_ready <= 1'b1;
         r_w_en     <= 1'b0;
         r_done     <= 1'b0;
         if (w_acc) begin
            case (r_state)
               S_IDLE, S_RUN: begin
                  if (rx_data == CMD_LOAD) begin
                     r_state    <= S_ADDR_H;
                     r_cpu_hold <= 1'b1;
                     r_busy     <= 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                     r_err      <= 1'b0;
                     r_sum      <= '0;
`endif
                  end else if (rx_data == CMD_RUN && w_run_ok) begin
                     r_state    <= S_RUN;
                     r_cpu_hold <= 1'b0;
                  end
               end
               S_ADDR_H: begin
                  r_addr[15:8] <= rx_data;
                  r_state      <= S_ADDR_L;
               end
               S_ADDR_L: begin
                  r_addr[7:0] <= rx_data;
                  r_state     <= S_LEN_H;
               end
               S_LEN_H: begin
                  r_len[15:8] <= rx_data;
                  r_state     <= S_LEN_L;
               end
               S_LEN_L: begin
                  r_len <= w_len_full;
                  if (w_len_full != '0) begin
                     r_state <= S_DATA;
                  end else begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                     r_state <= S_CSUM;
`else
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
`endif
                  end
               end
               S_DATA: begin
                  // Write lands one cycle after acceptance; done aligns with the final write
                  r_w_en   <= 1'b1;
                  r_w_addr <= r_addr[ADDR_WIDTH-1:0];
                  r_din    <= DATA_WIDTH'(rx_data);
                  r_addr   <= r_addr + 16'd1;
                  r_len    <= r_len - 16'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                  r_sum    <= r_sum + rx_data;
`endif
                  if (r_len == 16'd1) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                     r_state <= S_CSUM;
`else
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
`endif
                  end
               end
`ifdef IMEM_BOOT_CHECKSUM_EN
               S_CSUM: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  if (rx_data == r_sum) r_done <= 1'b1;
                  else                  r_err  <= 1'b1;
               end
`endif
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_ready   = r_rx_ready;
   assign cpu_hold   = r_cpu_hold;
   assign busy       = r_busy;
   assign done       = r_done;
   assign mem_w_en   = r_w_en;
   assign mem_w_addr = r_w_addr;
   assign mem_din    = r_din;
   assign mem_r_addr = cpu_r_addr;
   assign mem_r_en   = cpu_r_en & ~r_cpu_hold;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed table-driven bench for imem_boot_ctrl: load/run streams, address wrap, zero length,
// async reset mid-load, and (with IMEM_BOOT_CHECKSUM_EN) checksum match/mismatch.
module tb_imem_boot_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] cpu_r_addr;
   logic        cpu_r_en;
   logic        cpu_hold;
   logic [15:0] mem_w_addr;
   logic [7:0]  mem_din;
   logic        mem_w_en;
   logic [15:0] mem_r_addr;
   logic        mem_r_en;
   logic        busy;
   logic        done;
   logic        err;

   imem_boot_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .cpu_r_addr (cpu_r_addr),
      .cpu_r_en   (cpu_r_en),
      .cpu_hold   (cpu_hold),
      .mem_w_addr (mem_w_addr),
      .mem_din    (mem_din),
      .mem_w_en   (mem_w_en),
      .mem_r_addr (mem_r_addr),
      .mem_r_en   (mem_r_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        hold;
      logic        busy;
      logic        wen;
      logic [15:0] waddr;
      logic [7:0]  din;
      logic        done;
      logic        err;
      logic        ren;
      logic        rdy;
   } outs_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ren_in;
      outs_t      exp;
   } vec_t;

   vec_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic outs_t sample();
      return outs_t'({cpu_hold, busy, mem_w_en, mem_w_addr, mem_din, done, err, mem_r_en, rx_ready});
   endfunction

   task automatic check(input outs_t exp, input string name);
      outs_t act;
      act = sample();
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got hold=%b busy=%b wen=%b waddr=%h din=%h done=%b err=%b ren=%b rdy=%b, expected hold=%b busy=%b wen=%b waddr=%h din=%h done=%b err=%b ren=%b rdy=%b",
                    name, act.hold, act.busy, act.wen, act.waddr, act.din, act.done, act.err, act.ren, act.rdy,
                    exp.hold, exp.busy, exp.wen, exp.waddr, exp.din, exp.done, exp.err, exp.ren, exp.rdy);
   endtask

   // Push one vector: byte stimulus plus the outputs expected after the next edge
   task automatic vec(input logic v, input logic [7:0] d, input logic ren_in,
                      input logic hold, input logic bsy, input logic wen, input logic [15:0] wa,
                      input logic [7:0] din, input logic dn, input logic er, input logic ren);
      vec_t e;
      e.v      = v;
      e.d      = d;
      e.ren_in = ren_in;
      e.exp    = '{hold: hold, busy: bsy, wen: wen, waddr: wa, din: din,
                   done: dn, err: er, ren: ren, rdy: 1'b1};
      q.push_back(e);
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < q.size(); i++) begin
         rx_valid = q[i].v;
         rx_data  = q[i].d;
         cpu_r_en = q[i].ren_in;
         @(negedge clk);
         check(q[i].exp, $sformatf("%s[%0d]", tag, i));
      end
      q.delete();
      rx_valid = 1'b0;
   endtask

   task automatic check_addr(input logic [15:0] a);
      cpu_r_addr = a;
      #1;
      n_total++;
      if (mem_r_addr === a) n_pass++;
      else $display("FAIL r_addr: got %h expected %h", mem_r_addr, a);
   endtask

   outs_t rst_exp;

   initial begin
      rst_exp    = '{hold: 1'b1, busy: 1'b0, wen: 1'b0, waddr: 16'h0, din: 8'h0,
                     done: 1'b0, err: 1'b0, ren: 1'b0, rdy: 1'b0};
      rst_n      = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      cpu_r_en   = 1'b1;
      cpu_r_addr = 16'hBEEF;
      @(negedge clk);
      @(negedge clk);
      check(rst_exp, "reset");
      check_addr(16'hBEEF);
      rst_n = 1'b1;
      #1;
      check(rst_exp, "rdy_low_after_release");
      @(negedge clk);
      rst_exp.rdy = 1'b1;
      check(rst_exp, "rdy_high");

`ifndef IMEM_BOOT_CHECKSUM_EN
      // Stream A: three bytes at 0x0010, then RUN
      vec(1, 8'hA5, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h10, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h03, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h11, 1, 1,1,1,16'h0010,8'h11,0,0,0);
      vec(1, 8'h22, 1, 1,1,1,16'h0011,8'h22,0,0,0);
      vec(1, 8'h33, 1, 1,0,1,16'h0012,8'h33,1,0,0);
      vec(1, 8'h5A, 1, 0,0,0,16'h0012,8'h33,0,0,1);
      vec(0, 8'h00, 0, 0,0,0,16'h0012,8'h33,0,0,0);
      // Stream B: wrap at 0xFFFF with a stall between data bytes
      vec(1, 8'hA5, 1, 1,1,0,16'h0012,8'h33,0,0,0);
      vec(1, 8'hFF, 1, 1,1,0,16'h0012,8'h33,0,0,0);
      vec(1, 8'hFF, 1, 1,1,0,16'h0012,8'h33,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0012,8'h33,0,0,0);
      vec(1, 8'h02, 1, 1,1,0,16'h0012,8'h33,0,0,0);
      vec(1, 8'hAA, 1, 1,1,1,16'hFFFF,8'hAA,0,0,0);
      vec(0, 8'hCC, 1, 1,1,0,16'hFFFF,8'hAA,0,0,0);
      vec(1, 8'hBB, 1, 1,0,1,16'h0000,8'hBB,1,0,0);
      // Stream C: zero length, RUN, ignored byte, reload from RUN
      vec(1, 8'hA5, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h12, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h34, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h00, 1, 1,0,0,16'h0000,8'hBB,1,0,0);
      vec(1, 8'h5A, 1, 0,0,0,16'h0000,8'hBB,0,0,1);
      vec(1, 8'h77, 1, 0,0,0,16'h0000,8'hBB,0,0,1);
      vec(1, 8'hA5, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h20, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h04, 1, 1,1,0,16'h0000,8'hBB,0,0,0);
      vec(1, 8'h01, 1, 1,1,1,16'h0020,8'h01,0,0,0);
      vec(1, 8'h02, 1, 1,1,1,16'h0021,8'h02,0,0,0);
      run_vecs("main");

      // Async reset after 2 of 4 data bytes
      cpu_r_en = 1'b1;
      rst_n    = 1'b0;
      #1;
      rst_exp.rdy = 1'b0;
      check(rst_exp, "midload_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rst_exp.rdy = 1'b1;
      check(rst_exp, "midload_reset_release");

      // Fresh load after reset; an A5 inside the payload is plain data
      vec(1, 8'hA5, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h05, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h01, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'hA5, 1, 1,0,1,16'h0005,8'hA5,1,0,0);
      vec(1, 8'h5A, 1, 0,0,0,16'h0005,8'hA5,0,0,1);
      run_vecs("reload");
      check_addr(16'h0102);
`else
      // Checksum match: 01+02 = 03
      vec(1, 8'hA5, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h02, 1, 1,1,0,16'h0000,8'h00,0,0,0);
      vec(1, 8'h01, 1, 1,1,1,16'h0000,8'h01,0,0,0);
      vec(1, 8'h02, 1, 1,1,1,16'h0001,8'h02,0,0,0);
      vec(1, 8'h03, 1, 1,0,0,16'h0001,8'h02,1,0,0);
      // Checksum mismatch: err set, no done, RUN ignored
      vec(1, 8'hA5, 1, 1,1,0,16'h0001,8'h02,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0001,8'h02,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0001,8'h02,0,0,0);
      vec(1, 8'h00, 1, 1,1,0,16'h0001,8'h02,0,0,0);
      vec(1, 8'h02, 1, 1,1,0,16'h0001,8'h02,0,0,0);
      vec(1, 8'h01, 1, 1,1,1,16'h0000,8'h01,0,0,0);
      vec(1, 8'h02, 1, 1,1,1,16'h0001,8'h02,0,0,0);
      vec(1, 8'h04, 1, 1,0,0,16'h0001,8'h02,0,1,0);
      vec(1, 8'h5A, 1, 1,0,0,16'h0001,8'h02,0,1,0);
      vec(1, 8'hA5, 1, 1,1,0,16'h0001,8'h02,0,0,0);
      run_vecs("csum");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
